// File: rtl/cla_adder_seq.sv
// Multi-cycle carry-lookahead adder/subtractor: one GROUP-bit lookahead block per clock, LSB group first.
// Optional CLA_FLAGS_EN adds registered overflow/zero flags.

module cla_group #(
  parameter int GROUP = 4
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             ci,
  output logic [GROUP-1:0] s,
  output logic [GROUP:0]   c
);
  logic [GROUP-1:0] g, p;

  assign g = a & b;
  assign p = a | b;

  // Sum-of-products carry: c[n] = OR_j (g[j] & p[j+1..n-1]) | (p[0..n-1] & ci).
  function automatic logic la_carry(input int n, input logic [GROUP-1:0] gg,
                                    input logic [GROUP-1:0] pp, input logic c0);
    logic r, t;
    r = c0;
    for (int k = 0; k < n; k++) r = r & pp[k];
    for (int j = 0; j < n; j++) begin
      t = gg[j];
      for (int k = j + 1; k < n; k++) t = t & pp[k];
      r = r | t;
    end
    return r;
  endfunction

  assign c[0] = ci;
  for (genvar i = 0; i < GROUP; i++) begin : g_carry
    assign c[i+1] = la_carry(i + 1, g, p, ci);
  end

  assign s = a ^ b ^ c[GROUP-1:0];
endmodule

module cla_adder_seq #(
  parameter int WIDTH = 8,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             sub,
  input  logic             c_in,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Output,
  output logic             c_out,
  output logic             ready,
  output logic             busy
`ifdef CLA_FLAGS_EN
  ,
  output logic             overflow,
  output logic             zero
`endif
);
  localparam int NG = WIDTH / GROUP;
  localparam int CW = (NG > 1) ? $clog2(NG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NG - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    cnt;
  logic             cy;
  logic [WIDTH-1:0] a_q, b_q, acc, acc_nx;
  logic [GROUP-1:0] a_g, b_g, s_g;
  logic [GROUP:0]   c_g;
  logic             accept, last;

  assign accept = en && (state == IDLE || state == DONE);
  assign last   = (state == RUN) && (cnt == LAST);
  assign busy   = (state == RUN);
  assign ready  = (state == DONE);

  assign a_g = a_q[cnt*GROUP +: GROUP];
  assign b_g = b_q[cnt*GROUP +: GROUP];

  cla_group #(.GROUP(GROUP)) u_grp (
    .a  (a_g),
    .b  (b_g),
    .ci (cy),
    .s  (s_g),
    .c  (c_g)
  );

  always_comb begin
    acc_nx = acc;
    acc_nx[cnt*GROUP +: GROUP] = s_g;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (en) state_nx = RUN;
      RUN:     if (cnt == LAST) state_nx = DONE;
      DONE:    if (en) state_nx = RUN;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q    <= '0;
      b_q    <= '0;
      acc    <= '0;
      cnt    <= '0;
      cy     <= 1'b0;
      Output <= '0;
      c_out  <= 1'b0;
`ifdef CLA_FLAGS_EN
      overflow <= 1'b0;
      zero     <= 1'b0;
`endif
    end else if (accept) begin
      // Subtract is A + ~B + 1, so the inversion and forced carry happen at capture.
      a_q <= A;
      b_q <= sub ? ~B : B;
      cy  <= sub | c_in;
      cnt <= '0;
    end else if (state == RUN) begin
      acc <= acc_nx;
      cy  <= c_g[GROUP];
      cnt <= cnt + CW'(1);
      if (last) begin
        Output <= acc_nx;
        c_out  <= c_g[GROUP];
`ifdef CLA_FLAGS_EN
        overflow <= c_g[GROUP-1] ^ c_g[GROUP];
        zero     <= (acc_nx == '0);
`endif
      end
    end
  end
endmodule

// File: tb/tb_cla_adder_seq.sv
// Directed bench for cla_adder_seq at default WIDTH=8, GROUP=4 (two cycles per op).
// Flag checks compile in only when CLA_FLAGS_EN is defined.

module tb_cla_adder_seq;
  logic       clk = 1'b0;
  logic       reset, en, sub, c_in;
  logic [7:0] A, B, Output;
  logic       c_out, ready, busy;
`ifdef CLA_FLAGS_EN
  logic       overflow, zero;
`endif
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cla_adder_seq #(.WIDTH(8), .GROUP(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .sub    (sub),
    .c_in   (c_in),
    .A      (A),
    .B      (B),
    .Output (Output),
    .c_out  (c_out),
    .ready  (ready),
    .busy   (busy)
`ifdef CLA_FLAGS_EN
    ,
    .overflow (overflow),
    .zero     (zero)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one op, check the busy window, then the held result.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic s, input logic ci, input logic [7:0] prev,
                        input logic [7:0] exp_o, input logic exp_c,
                        input logic exp_ov, input logic exp_z);
    A = a; B = b; sub = s; c_in = ci; en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    chk({tag, "_busy1"}, busy, 1);
    chk({tag, "_rdy1"}, ready, 0);
    @(negedge clk);
    chk({tag, "_busy2"}, busy, 1);
    chk({tag, "_hold"}, Output, prev);
    @(negedge clk);
    chk({tag, "_rdy"}, {busy, ready}, 2'b01);
    chk({tag, "_out"}, Output, exp_o);
    chk({tag, "_cout"}, c_out, exp_c);
`ifdef CLA_FLAGS_EN
    chk({tag, "_ovf"}, overflow, exp_ov);
    chk({tag, "_zero"}, zero, exp_z);
`else
    if (exp_ov & exp_z) $display("note: %s flag vector unused", tag);
`endif
    repeat (2) @(negedge clk);
    chk({tag, "_held"}, {ready, Output}, {1'b1, exp_o});
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; sub = 1'b0; c_in = 1'b0; A = '0; B = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out", Output, 8'h00);
    chk("rst_flags", {c_out, ready, busy}, 3'b000);

    run_op("add1", 8'h3C, 8'h05, 1'b0, 1'b0, 8'h00, 8'h41, 1'b0, 1'b0, 1'b0);
    run_op("addff", 8'hFF, 8'h00, 1'b0, 1'b1, 8'h41, 8'h00, 1'b1, 1'b0, 1'b1);
    run_op("sub1", 8'h10, 8'h20, 1'b1, 1'b1, 8'h00, 8'hF0, 1'b0, 1'b0, 1'b0);
    run_op("subov", 8'h80, 8'h01, 1'b1, 1'b0, 8'hF0, 8'h7F, 1'b1, 1'b1, 1'b0);

    // Operands change and en stays high during RUN; en still high in DONE restarts.
    A = 8'h12; B = 8'h34; sub = 1'b0; c_in = 1'b0; en = 1'b1;
    @(negedge clk);
    A = 8'hAA; B = 8'h55;
    chk("chg_busy", busy, 1);
    @(negedge clk);
    chk("chg_hold", Output, 8'h7F);
    @(negedge clk);
    chk("chg_rdy", ready, 1);
    chk("chg_out", Output, 8'h46);
    @(negedge clk);
    en = 1'b0;
    chk("re_rdy0a", {busy, ready}, 2'b10);
    @(negedge clk);
    chk("re_rdy0b", {busy, ready}, 2'b10);
    chk("re_hold", Output, 8'h46);
    @(negedge clk);
    chk("re_rdy", ready, 1);
    chk("re_out", Output, 8'hFF);
    chk("re_cout", c_out, 0);

    // Reset on the first RUN cycle discards the op.
    A = 8'h01; B = 8'h01; en = 1'b1;
    @(negedge clk);
    en = 1'b0; reset = 1'b1;
    @(negedge clk);
    chk("mr_out", Output, 8'h00);
    chk("mr_flags", {c_out, ready, busy}, 3'b000);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("mr_idle", {ready, busy, Output}, 10'h000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
